// File: rtl/orv64_div_sched.sv
// Shares one iterative divider between N_REQ requesters. Grants round-robin,
// sequences the divider's start/complete protocol, holds the divider operands
// stable for the whole operation and reuses the last quotient/remainder pair
// when a new request carries identical operands and signedness/width.
//
// Handshake semantics: a requester holds req_valid and its operands stable
// until it sees req_ready; a transfer happens on a clock edge where both are
// high. A result transfers on an edge where resp_valid[owner] and
// resp_ready[owner] are both high; resp_valid/resp_data stay stable until then.
module orv64_div_sched #(
  parameter int N_REQ      = 2,
  parameter int DIV_TYPE_W = 3,
  parameter bit CACHE_EN   = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*64-1:0]          req_rs1,
  input  logic [N_REQ*64-1:0]          req_rs2,
  input  logic [N_REQ*DIV_TYPE_W-1:0]  req_type,
  input  logic [N_REQ-1:0]             req_kill,
  output logic [N_REQ-1:0]             resp_valid,
  input  logic [N_REQ-1:0]             resp_ready,
  output logic [63:0]                  resp_data,
  input  logic                         cache_inv,
  output logic                         div_start,
  output logic [63:0]                  div_rs1,
  output logic [63:0]                  div_rs2,
  output logic [DIV_TYPE_W-1:0]        div_type,
  input  logic                         div_complete,
  input  logic [63:0]                  div_rdq,
  input  logic [63:0]                  div_rdr,
  output logic                         busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // State is kept in state_q so that checkers can bind to it directly.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e             state_q;
  state_e             state_d;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_vld;
  logic [63:0]        sel_rs1;
  logic [63:0]        sel_rs2;
  logic [DIV_TYPE_W-1:0] sel_type;
  logic               cache_hit;
  logic               accept;
  logic               fill;

  // Reuse cache: operands, signedness/width mode and both results.
  logic               cache_vld_q;
  logic [63:0]        c_rs1_q;
  logic [63:0]        c_rs2_q;
  logic [1:0]         c_mode_q;
  logic [63:0]        c_rdq_q;
  logic [63:0]        c_rdr_q;

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % N_REQ);
  endfunction

  // Round-robin pick: first valid requester after rr_ptr, wrapping around.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!grant_vld && req_valid[wrap_idx(int'(rr_ptr_q) + k)]) begin
        grant_vld = 1'b1;
        grant_idx = wrap_idx(int'(rr_ptr_q) + k);
      end
    end
  end

  // Operands of the candidate requester and the reuse-cache lookup.
  always_comb begin
    sel_rs1   = req_rs1[64*grant_idx +: 64];
    sel_rs2   = req_rs2[64*grant_idx +: 64];
    sel_type  = req_type[DIV_TYPE_W*grant_idx +: DIV_TYPE_W];
    cache_hit = CACHE_EN && cache_vld_q && !cache_inv &&
                (sel_rs1 == c_rs1_q) && (sel_rs2 == c_rs2_q) &&
                (sel_type[2:1] == c_mode_q);
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    resp_valid = '0;
    div_start  = 1'b0;
    accept     = 1'b0;
    fill       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          req_ready[grant_idx] = 1'b1;
          accept               = 1'b1;
          state_d              = cache_hit ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        div_start = 1'b1;
        state_d   = req_kill[owner_q] ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (div_complete) begin
          fill    = 1'b1;
          state_d = req_kill[owner_q] ? S_IDLE : S_RESP;
        end else if (req_kill[owner_q]) begin
          state_d = S_DRAIN;
        end
      end
      S_RESP: begin
        if (req_kill[owner_q]) begin
          state_d = S_IDLE;
        end else begin
          resp_valid[owner_q] = 1'b1;
          if (resp_ready[owner_q]) state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (div_complete) begin
          fill    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);

  // State, owner/pointer, divider operand registers and response data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      div_rs1   <= '0;
      div_rs2   <= '0;
      div_type  <= '0;
      resp_data <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q  <= grant_idx;
        rr_ptr_q <= grant_idx;
        div_rs1  <= sel_rs1;
        div_rs2  <= sel_rs2;
        div_type <= sel_type;
        if (cache_hit) resp_data <= sel_type[0] ? c_rdr_q : c_rdq_q;
      end
      if (fill && (state_q == S_WAIT)) resp_data <= div_type[0] ? div_rdr : div_rdq;
    end
  end

  // Reuse cache fill; an invalidate in the same cycle as a fill wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_vld_q <= 1'b0;
      c_rs1_q     <= '0;
      c_rs2_q     <= '0;
      c_mode_q    <= '0;
      c_rdq_q     <= '0;
      c_rdr_q     <= '0;
    end else begin
      if (fill) begin
        c_rs1_q  <= div_rs1;
        c_rs2_q  <= div_rs2;
        c_mode_q <= div_type[2:1];
        c_rdq_q  <= div_rdq;
        c_rdr_q  <= div_rdr;
      end
      if (cache_inv)  cache_vld_q <= 1'b0;
      else if (fill)  cache_vld_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_orv64_div_sched.sv
// Bench for orv64_div_sched: behavioural divider on the divider side,
// directed scenarios followed by randomized traffic, checked against a
// transaction-level model (last grantee + one-entry result cache).
module tb_orv64_div_sched;

  localparam int N  = 2;
  localparam int TW = 3;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*64-1:0] req_rs1;
  logic [N*64-1:0] req_rs2;
  logic [N*TW-1:0] req_type;
  logic [N-1:0]    req_kill;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready;
  logic [63:0]     resp_data;
  logic            cache_inv;
  logic            div_start;
  logic [63:0]     div_rs1;
  logic [63:0]     div_rs2;
  logic [TW-1:0]   div_type;
  logic            div_complete;
  logic [63:0]     div_rdq;
  logic [63:0]     div_rdr;
  logic            busy;

  orv64_div_sched #(.N_REQ(N), .DIV_TYPE_W(TW), .CACHE_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_type(req_type),
    .req_kill(req_kill),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .cache_inv(cache_inv),
    .div_start(div_start), .div_rs1(div_rs1), .div_rs2(div_rs2), .div_type(div_type),
    .div_complete(div_complete), .div_rdq(div_rdq), .div_rdr(div_rdr),
    .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters and checker ----------------
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference arithmetic (RISC-V DIV/REM family) ----------------
  function automatic logic [127:0] div_fn(input logic [63:0] a, input logic [63:0] b,
                                          input logic [2:0] t);
    logic [63:0] x, y, q, r;
    if (t[2]) begin
      x = t[1] ? {32'b0, a[31:0]} : {{32{a[31]}}, a[31:0]};
      y = t[1] ? {32'b0, b[31:0]} : {{32{b[31]}}, b[31:0]};
    end else begin
      x = a;
      y = b;
    end
    if (y == 64'd0) begin
      q = '1;
      r = x;
    end else if (t[1]) begin
      q = x / y;
      r = x % y;
    end else if (x == 64'h8000_0000_0000_0000 && y == '1) begin
      q = x;
      r = 64'd0;
    end else begin
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end
    if (t[2]) begin
      q = {{32{q[31]}}, q[31:0]};
      r = {{32{r[31]}}, r[31:0]};
    end
    return {r, q};
  endfunction

  // ---------------- behavioural divider ----------------
  int          dcnt = 0;
  int          start_cnt = 0;
  logic [63:0] d_rs1, d_rs2;
  logic [2:0]  d_type;

  initial begin
    div_complete = 1'b0;
    div_rdq = '0;
    div_rdr = '0;
    forever begin
      @(negedge clk);
      div_complete = 1'b0;
      if (!rst_n) begin
        dcnt = 0;
      end else if (div_start) begin
        chk("div_start_overlap", 64'(dcnt), 64'd0);
        start_cnt++;
        dcnt   = $urandom_range(1, 5);
        d_rs1  = div_rs1;
        d_rs2  = div_rs2;
        d_type = div_type;
      end else if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          chk("div_rs1_stable", div_rs1, d_rs1);
          chk("div_rs2_stable", div_rs2, d_rs2);
          chk("div_type_stable", 64'(div_type), 64'(d_type));
          {div_rdr, div_rdq} = div_fn(d_rs1, d_rs2, d_type);
          div_complete = 1'b1;
        end
      end
    end
  end

  // ---------------- requester model state ----------------
  bit          p_vld [N];
  logic [63:0] p_rs1 [N];
  logic [63:0] p_rs2 [N];
  logic [2:0]  p_type[N];

  // transaction-level reference: last grantee and one cached result pair
  int          m_last;
  bit          m_cvld;
  logic [63:0] m_crs1, m_crs2, m_cq, m_cr;
  logic [1:0]  m_cmode;

  logic [63:0] cur_rs1, cur_rs2, cur_q, cur_r;
  logic [2:0]  cur_type;
  int          cur_s0;

  task automatic apply_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = p_vld[i];
      req_rs1[i*64 +: 64]    = p_rs1[i];
      req_rs2[i*64 +: 64]    = p_rs2[i];
      req_type[i*TW +: TW]   = p_type[i];
    end
  endtask

  function automatic int exp_grant();
    for (int k = 1; k <= N; k++) begin
      if (p_vld[(m_last + k) % N]) return (m_last + k) % N;
    end
    return 0;
  endfunction

  task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] t);
    p_vld[i]  = 1'b1;
    p_rs1[i]  = a;
    p_rs2[i]  = b;
    p_type[i] = t;
  endtask

  task automatic new_req(input int i, input bit reuse, input logic [2:0] t);
    logic [63:0] a, b;
    case ($urandom_range(0, 3))
      0:       a = {$urandom, $urandom};
      1:       a = 64'($urandom_range(0, 1000));
      2:       a = 64'h8000_0000_0000_0000;
      default: a = 64'hFFFF_FFFF_8000_0000;
    endcase
    case ($urandom_range(0, 3))
      0:       b = {$urandom, $urandom};
      1:       b = 64'($urandom_range(1, 50));
      2:       b = 64'd0;
      default: b = '1;
    endcase
    if (reuse && m_cvld) begin
      a = m_crs1;
      b = m_crs2;
    end
    set_req(i, a, b, t);
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a negedge with the DUT idle and at least one request pending.
  task automatic accept_req(output int g, output bit hit, output logic [63:0] exp_d);
    logic [127:0] res;
    apply_reqs();
    #1;
    g = exp_grant();
    chk("req_ready_grant", 64'(req_ready), 64'(1) << g);
    cur_rs1  = p_rs1[g];
    cur_rs2  = p_rs2[g];
    cur_type = p_type[g];
    hit = m_cvld && (cur_rs1 == m_crs1) && (cur_rs2 == m_crs2) && (cur_type[2:1] == m_cmode);
    res   = div_fn(cur_rs1, cur_rs2, cur_type);
    cur_q = res[63:0];
    cur_r = res[127:64];
    exp_d = cur_type[0] ? cur_r : cur_q;
    if (hit) exp_d = cur_type[0] ? m_cr : m_cq;
    cur_s0 = start_cnt;
    @(posedge clk);
    p_vld[g] = 1'b0;
    m_last   = g;
  endtask

  task automatic model_fill(input bit inv);
    m_cvld  = !inv;
    m_crs1  = cur_rs1;
    m_crs2  = cur_rs2;
    m_cmode = cur_type[2:1];
    m_cq    = cur_q;
    m_cr    = cur_r;
  endtask

  task automatic wait_resp(input int g, input bit hit, input logic [63:0] exp_d,
                           input int bp, input bit inv_fill);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      apply_reqs();
      #1;
      cache_inv = inv_fill && div_complete;
      if (resp_valid != '0) seen = 1'b1;
      else chk("req_ready_busy", 64'(req_ready), 64'd0);
    end
    cache_inv = 1'b0;
    chk("resp_seen", 64'(seen), 64'd1);
    if (!seen) return;
    chk("resp_valid", 64'(resp_valid), 64'(1) << g);
    chk("resp_data", resp_data, exp_d);
    chk("div_starts", 64'(start_cnt - cur_s0), hit ? 64'd0 : 64'd1);
    if (hit) chk("hit_latency", 64'(n), 64'd1);
    repeat (bp) begin
      @(negedge clk);
      #1;
      chk("bp_resp_valid", 64'(resp_valid), 64'(1) << g);
      chk("bp_resp_data", resp_data, exp_d);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    resp_ready[g] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = '0;
    #1;
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_resp_valid", 64'(resp_valid), 64'd0);
    if (!hit) model_fill(1'b0);
    if (!hit && inv_fill) m_cvld = 1'b0;
  endtask

  task automatic run_txn(input int bp, input bit inv_fill);
    int g;
    bit hit;
    logic [63:0] e;
    accept_req(g, hit, e);
    wait_resp(g, hit, e, bp, inv_fill);
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({pfx, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({pfx, "_div_start"}, 64'(div_start), 64'd0);
    chk({pfx, "_div_rs1"}, div_rs1, 64'd0);
    chk({pfx, "_div_rs2"}, div_rs2, 64'd0);
    chk({pfx, "_div_type"}, 64'(div_type), 64'd0);
    chk({pfx, "_resp_data"}, resp_data, 64'd0);
    chk({pfx, "_busy"}, 64'(busy), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    err_cnt++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // ---------------- main stimulus ----------------
  initial begin
    int g, n;
    bit hit, seen, done;
    logic [63:0] e;

    rst_n = 1'b1;
    req_valid = '0; req_rs1 = '0; req_rs2 = '0; req_type = '0;
    req_kill = '0; resp_ready = '0; cache_inv = 1'b0;
    for (int i = 0; i < N; i++) begin
      p_vld[i] = 1'b0; p_rs1[i] = '0; p_rs2[i] = '0; p_type[i] = '0;
    end
    m_last = 0; m_cvld = 1'b0;
    m_crs1 = '0; m_crs2 = '0; m_cq = '0; m_cr = '0; m_cmode = '0;

    // reset state
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // basic miss, reuse hit with REM, then DIVU on same operands misses
    set_req(0, 64'd100, 64'd7, 3'b000);
    run_txn(0, 1'b0);
    set_req(0, 64'd100, 64'd7, 3'b001);
    run_txn(0, 1'b0);
    set_req(0, 64'd100, 64'd7, 3'b010);
    run_txn(0, 1'b0);

    // round-robin with both requesters continuously valid
    new_req(0, 1'b0, 3'($urandom_range(0, 7)));
    new_req(1, 1'b0, 3'($urandom_range(0, 7)));
    for (int k = 0; k < 4; k++) begin
      accept_req(g, hit, e);
      if (k < 2) new_req(g, 1'b0, 3'($urandom_range(0, 7)));
      wait_resp(g, hit, e, 0, 1'b0);
    end

    // backpressure for 5 cycles
    set_req(1, 64'd123456, 64'd10, 3'b000);
    run_txn(5, 1'b0);

    // invalidate coinciding with the fill: the repeat must miss
    set_req(0, 64'd77777, 64'd13, 3'b000);
    run_txn(0, 1'b1);
    set_req(0, 64'd77777, 64'd13, 3'b001);
    run_txn(0, 1'b0);

    // kill the owner while waiting: no response, cache still filled
    set_req(1, 64'd1000, 64'd33, 3'b000);
    accept_req(g, hit, e);
    n = 0; seen = 1'b0; done = 1'b0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      apply_reqs();
      req_kill = '0;
      if (n == 2) req_kill[g] = 1'b1;
      #1;
      if (resp_valid != '0) seen = 1'b1;
      if (n == 2) chk("kill_busy_held", 64'(busy), 64'd1);
      if (n > 2 && !busy) done = 1'b1;
    end
    req_kill = '0;
    chk("kill_done", 64'(done), 64'd1);
    chk("kill_no_resp", 64'(seen), 64'd0);
    chk("kill_starts", 64'(start_cnt - cur_s0), 64'd1);
    chk("kill_div_finished", 64'(dcnt), 64'd0);
    model_fill(1'b0);
    set_req(0, 64'd1000, 64'd33, 3'b001);
    run_txn(0, 1'b0);

    // kill while the response is pending: resp_valid drops, back to idle
    set_req(0, 64'd5555, 64'd3, 3'b000);
    accept_req(g, hit, e);
    n = 0; seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      apply_reqs();
      #1;
      if (resp_valid != '0) seen = 1'b1;
    end
    chk("rkill_resp_seen", 64'(seen), 64'd1);
    chk("rkill_resp_data", resp_data, e);
    @(negedge clk);
    req_kill[g] = 1'b1;
    #1 chk("rkill_valid_drop", 64'(resp_valid), 64'd0);
    @(negedge clk);
    req_kill = '0;
    #1;
    chk("rkill_busy", 64'(busy), 64'd0);
    chk("rkill_resp_valid", 64'(resp_valid), 64'd0);
    if (!hit) model_fill(1'b0);

    // asynchronous reset while waiting on the divider
    set_req(1, 64'd999, 64'd4, 3'b000);
    accept_req(g, hit, e);
    @(negedge clk);
    apply_reqs();
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_cvld = 1'b0;
    m_last = 0;
    @(negedge clk);
    #1 chk("midrst_no_resp", 64'(resp_valid), 64'd0);
    set_req(0, 64'd1000, 64'd33, 3'b001);
    run_txn(0, 1'b0);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      bit any;
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!p_vld[i] && $urandom_range(0, 9) < 7)
          new_req(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        if (p_vld[i]) any = 1'b1;
      end
      if (any) begin
        run_txn($urandom_range(0, 3), 1'b0);
      end else begin
        bit inv;
        @(negedge clk);
        inv = 1'($urandom_range(0, 1));
        cache_inv = inv;
        @(negedge clk);
        cache_inv = 1'b0;
        if (inv) m_cvld = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
